// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             zero;
    logic             dmem_ready;
    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic [1:0]       npc_sel;
    logic             rd_sel;
    logic             jal_sel;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic             mem_to_reg;
    logic             dmem_req;
    logic             dmem_we;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             err;

    modport master (
        input  opcode, func, zero, dmem_ready,
        output pc_we, ir_we, reg_we, npc_sel, rd_sel, jal_sel, alu_src, alu_op,
               mem_to_reg, dmem_req, dmem_we, state, retired, err
    );

    modport slave (
        output opcode, func, zero, dmem_ready,
        input  pc_we, ir_we, reg_we, npc_sel, rd_sel, jal_sel, alu_src, alu_op,
               mem_to_reg, dmem_req, dmem_we, state, retired, err
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a bounded data-memory wait, retired-instruction counter and sticky timeout flag.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  ctrl
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP  = 4'd0,
        I_ADDU = 4'd1,
        I_SUBU = 4'd2,
        I_JR   = 4'd3,
        I_ORI  = 4'd4,
        I_LUI  = 4'd5,
        I_LW   = 4'd6,
        I_SW   = 4'd7,
        I_BEQ  = 4'd8,
        I_JAL  = 4'd9
    } instr_t;

    // Unsupported opcodes, and R-type with an unknown func, collapse to nop.
    function automatic instr_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
        instr_t res;
        res = I_NOP;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: res = I_ADDU;
                    FN_SUBU: res = I_SUBU;
                    FN_JR:   res = I_JR;
                    default: res = I_NOP;
                endcase
            end
            OP_ORI:  res = I_ORI;
            OP_LUI:  res = I_LUI;
            OP_LW:   res = I_LW;
            OP_SW:   res = I_SW;
            OP_BEQ:  res = I_BEQ;
            OP_JAL:  res = I_JAL;
            default: res = I_NOP;
        endcase
        return res;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    logic             r_err;
    logic [7:0]       r_wait;

    state_t           w_next;
    instr_t           w_instr;
    logic             w_retire;
    logic             w_timeout;
    logic [7:0]       w_wait_next;
    logic             w_pc_we;
    logic             w_ir_we;
    logic             w_reg_we;
    logic [1:0]       w_npc_sel;
    logic             w_rd_sel;
    logic             w_jal_sel;
    logic             w_alu_src;
    logic [2:0]       w_alu_op;
    logic             w_mem_to_reg;
    logic             w_dmem_req;
    logic             w_dmem_we;

    assign w_instr = decode_instr(ctrl.opcode, ctrl.func);

    // Next-state and per-state control decode.
    always_comb begin
        w_next       = S_FETCH;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        w_pc_we      = 1'b0;
        w_ir_we      = 1'b0;
        w_reg_we     = 1'b0;
        w_npc_sel    = 2'd0;
        w_rd_sel     = 1'b0;
        w_jal_sel    = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 3'd0;
        w_mem_to_reg = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                case (w_instr)
                    I_JAL: begin
                        w_reg_we  = 1'b1;
                        w_jal_sel = 1'b1;
                        w_pc_we   = 1'b1;
                        w_npc_sel = 2'd2;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    I_JR: begin
                        w_pc_we   = 1'b1;
                        w_npc_sel = 2'd3;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    I_NOP: begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (w_instr)
                    I_ADDU: begin w_alu_op = 3'd0; w_alu_src = 1'b0; w_next = S_WB;  end
                    I_SUBU: begin w_alu_op = 3'd1; w_alu_src = 1'b0; w_next = S_WB;  end
                    I_ORI:  begin w_alu_op = 3'd2; w_alu_src = 1'b1; w_next = S_WB;  end
                    I_LUI:  begin w_alu_op = 3'd3; w_alu_src = 1'b1; w_next = S_WB;  end
                    I_LW:   begin w_alu_op = 3'd0; w_alu_src = 1'b1; w_next = S_MEM; end
                    I_SW:   begin w_alu_op = 3'd0; w_alu_src = 1'b1; w_next = S_MEM; end
                    I_BEQ: begin
                        w_alu_op  = 3'd1;
                        w_pc_we   = ctrl.zero;
                        w_npc_sel = 2'd1;
                        w_retire  = 1'b1;
                        w_next    = S_FETCH;
                    end
                    default: begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_instr == I_SW);
                w_alu_src  = 1'b1;
                // Ready wins over a timeout landing in the same cycle.
                if (ctrl.dmem_ready) begin
                    if (w_instr == I_LW) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_rd_sel     = !((w_instr == I_ADDU) || (w_instr == I_SUBU));
                w_mem_to_reg = (w_instr == I_LW);
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // The counter only runs while MEM is held; any other transition clears it.
    assign w_wait_next = ((r_state == S_MEM) && (w_next == S_MEM)) ? (r_wait + 8'd1) : 8'd0;

    // State, wait counter, retire counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_err     <= 1'b0;
            r_wait    <= 8'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ctrl.pc_we      = w_pc_we    & ~reset;
    assign ctrl.ir_we      = w_ir_we    & ~reset;
    assign ctrl.reg_we     = w_reg_we   & ~reset;
    assign ctrl.dmem_req   = w_dmem_req & ~reset;
    assign ctrl.dmem_we    = w_dmem_we  & ~reset;
    assign ctrl.npc_sel    = w_npc_sel;
    assign ctrl.rd_sel     = w_rd_sel;
    assign ctrl.jal_sel    = w_jal_sel;
    assign ctrl.alu_src    = w_alu_src;
    assign ctrl.alu_op     = w_alu_op;
    assign ctrl.mem_to_reg = w_mem_to_reg;
    assign ctrl.state      = r_state;
    assign ctrl.retired    = r_retired;
    assign ctrl.err        = r_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios followed by random instruction
// streams, checked against an instruction-level model of state paths and outputs.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4;
    localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_JAL = 8, K_NOP = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic             exp_err = 1'b0;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // {pc_we, ir_we, reg_we, npc_sel, rd_sel, jal_sel, alu_src, alu_op, mem_to_reg, dmem_req, dmem_we}
    function automatic logic [13:0] obs_vec();
        return {bus.pc_we, bus.ir_we, bus.reg_we, bus.npc_sel, bus.rd_sel, bus.jal_sel,
                bus.alu_src, bus.alu_op, bus.mem_to_reg, bus.dmem_req, bus.dmem_we};
    endfunction

    function automatic logic [13:0] exp_vec(input int s, input int k, input logic z);
        logic pc, ir, rw, rs, js, as, mr, dq, dw;
        logic [1:0] ns;
        logic [2:0] ao;
        {pc, ir, rw, rs, js, as, mr, dq, dw} = 9'd0;
        ns = 2'd0;
        ao = 3'd0;
        if (s == 0) begin
            pc = 1'b1; ir = 1'b1;
        end else if (s == 1) begin
            if (k == K_JAL) begin pc = 1'b1; rw = 1'b1; js = 1'b1; ns = 2'd2; end
            if (k == K_JR)  begin pc = 1'b1; ns = 2'd3; end
        end else if (s == 2) begin
            if (k == K_SUBU || k == K_BEQ) ao = 3'd1;
            if (k == K_ORI) ao = 3'd2;
            if (k == K_LUI) ao = 3'd3;
            as = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
            if (k == K_BEQ) begin pc = z; ns = 2'd1; end
        end else if (s == 3) begin
            dq = 1'b1; as = 1'b1; dw = (k == K_SW);
        end else begin
            rw = 1'b1; rs = !(k == K_ADDU || k == K_SUBU); mr = (k == K_LW);
        end
        return {pc, ir, rw, ns, rs, js, as, ao, mr, dq, dw};
    endfunction

    task automatic set_instr(input int k);
        logic [5:0] op, fn;
        op = 6'd0;
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADDU: fn = 6'h21;
            K_SUBU: fn = 6'h23;
            K_JR:   fn = 6'h08;
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_JAL:  op = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'($urandom_range(0, 63));
                end else begin
                    op = 6'($urandom_range(1, 63));
                    while (op inside {6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03})
                        op = 6'($urandom_range(1, 63));
                end
            end
        endcase
        bus.opcode = op;
        bus.func   = fn;
    endtask

    // Entered at a negedge in FETCH; returns at the negedge of the next FETCH.
    // delay = number of not-ready MEM cycles before dmem_ready rises.
    task automatic run_instr(input int k, input logic z, input int delay, input string tag);
        int  q[$];
        int  midx;
        bit  to;
        chk({tag, "_ret_before"}, 32'(bus.retired), 32'(exp_ret));
        chk({tag, "_err_before"}, 32'(bus.err), 32'(exp_err));
        set_instr(k);
        bus.zero = z;
        to = (k == K_LW || k == K_SW) && (delay >= TIMEOUT);
        q = {0, 1};
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ}) q.push_back(2);
        if (k == K_LW || k == K_SW) repeat (to ? TIMEOUT : delay + 1) q.push_back(3);
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI} || (k == K_LW && !to)) q.push_back(4);
        midx = 0;
        foreach (q[i]) begin
            if (q[i] == 3) begin
                bus.dmem_ready = (midx == delay);
                midx++;
            end else begin
                bus.dmem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk($sformatf("%s_c%0d_state", tag, i), 32'(bus.state), 32'(q[i]));
            chk($sformatf("%s_c%0d_outs", tag, i), 32'(obs_vec()), 32'(exp_vec(q[i], k, z)));
            @(negedge clk);
        end
        if (to) exp_err = 1'b1;
        else    exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        bus.opcode = 6'd0;
        bus.func = 6'd0;
        bus.zero = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_enables", 32'({bus.pc_we, bus.ir_we, bus.reg_we, bus.dmem_req, bus.dmem_we}), 32'd0);
        reset = 1'b0;

        run_instr(K_ADDU, 1'b0, 0, "addu");
        run_instr(K_LW,   1'b0, 2, "lw_wait2");
        run_instr(K_BEQ,  1'b1, 0, "beq_taken");
        run_instr(K_BEQ,  1'b0, 0, "beq_not");
        run_instr(K_JAL,  1'b0, 0, "jal");
        run_instr(K_SW,   1'b0, 3, "sw_ready_at_limit");
        run_instr(K_SW,   1'b0, 99, "sw_timeout");
        run_instr(K_NOP,  1'b0, 0, "nop_after_to");

        // Reset in the second MEM cycle of a load.
        chk("lwrst_err_before", 32'(bus.err), 32'(exp_err));
        set_instr(K_LW);
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("lwrst_c%0d_state", i), 32'(bus.state), 32'(i));
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("lwrst_gated", 32'({bus.pc_we, bus.ir_we, bus.reg_we, bus.dmem_req, bus.dmem_we}), 32'd0);
        @(negedge clk);
        #1;
        chk("lwrst_state", 32'(bus.state), 32'd0);
        chk("lwrst_retired", 32'(bus.retired), 32'd0);
        chk("lwrst_err", 32'(bus.err), 32'd0);
        chk("lwrst_dmem_reg", 32'({bus.dmem_req, bus.reg_we}), 32'd0);
        reset = 1'b0;
        exp_ret = '0;
        exp_err = 1'b0;

        for (int n = 0; n < 320; n++) begin
            run_instr($urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                      $sformatf("rnd%0d", n));
        end
        #1;
        chk("final_state", 32'(bus.state), 32'd0);
        chk("final_retired", 32'(bus.retired), 32'(exp_ret));
        chk("final_err", 32'(bus.err), 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in MEM waiting for dmem_ready, range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 opcode  input  6  instruction bits [31:26] from the field decoder; stable from DECODE to end of instruction.
REQ-006 func  input  6  instruction bits [5:0] from the field decoder.
REQ-007 zero  input  1  ALU equal flag, valid in EXEC.
REQ-008 dmem_ready  input  1  data-memory completion, sampled in MEM.
REQ-009 pc_we, ir_we, reg_we  output  1 each  write enables for PC, IR and register file.
REQ-010 npc_sel  output  2  next-PC select: 0 PC+4, 1 branch target, 2 jump target (26-bit field), 3 register rs.
REQ-011 rd_sel  output  1  write-register select: 0 rd field, 1 rt field.
REQ-012 jal_sel  output  1  forces write register 31 and write data PC+4; overrides rd_sel.
REQ-013 alu_src  output  1  0 rt register, 1 extended imm.
REQ-014 alu_op  output  3  0 add, 1 sub, 2 or, 3 lui (imm<<16); other codes unused.
REQ-015 mem_to_reg, dmem_req, dmem_we  output  1 each  write-back source, memory request, memory write.
REQ-016 state  output  3  current state encoding, for debug.
REQ-017 retired  output  CNT_W  count of completed instructions.
REQ-018 err  output  1  sticky memory-timeout flag.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5..7 SHALL go to FETCH next cycle with all enables 0.
REQ-020 Supported: addu (op 0, func 0x21), subu (op 0, func 0x23), jr (op 0, func 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, jal 0x03; anything else, including op 0 with other func, is a nop.
REQ-021 FETCH: ir_we=1, pc_we=1, npc_sel=0; always -> DECODE.
REQ-022 DECODE, jal: reg_we=1, jal_sel=1, pc_we=1, npc_sel=2; -> FETCH, instruction retires.
REQ-023 DECODE, jr: pc_we=1, npc_sel=3; -> FETCH, retires.
REQ-024 DECODE, nop: no enables; -> FETCH, retires.
REQ-025 DECODE, other supported ops: no enables; -> EXEC.
REQ-026 EXEC: alu_op/alu_src per op (addu 0/0, subu 1/0, ori 2/1, lui 3/1, lw/sw 0/1, beq 1/0); R-type, ori, lui -> WB; lw, sw -> MEM.
REQ-027 EXEC, beq: pc_we=zero, npc_sel=1; -> FETCH, retires whether taken or not.
REQ-028 MEM: dmem_req=1 every cycle in MEM; dmem_we=1 only for sw; alu_op=0 and alu_src=1 held.
REQ-029 MEM, dmem_ready=1: lw -> WB; sw -> FETCH, retires.
REQ-030 MEM wait counter SHALL clear on MEM entry and increment each cycle dmem_ready=0.
REQ-031 Timeout: when the counter reaches TIMEOUT with dmem_ready=0, err SHALL set and the state -> FETCH, no retire; dmem_ready and timeout in the same cycle resolve as ready.
REQ-032 WB: reg_we=1; rd_sel=0 for R-type, 1 otherwise; mem_to_reg=1 only for lw; -> FETCH, retires.
REQ-033 Outputs other than state, retired and err SHALL be combinational from state, opcode, func and zero; all outputs not listed for a state SHALL be 0.
REQ-034 retired SHALL increment on the last cycle of each instruction and wrap from all-ones to 0.
REQ-035 Latencies: jal/jr/nop 2 cycles; beq 3; addu/subu/ori/lui 4; sw 4+wait; lw 5+wait.

Reset
REQ-036 reset=1 SHALL force state=FETCH, retired=0, err=0 and the wait counter to 0 on the next edge, from any state including mid-MEM.
REQ-037 While reset=1, all write enables, dmem_req and dmem_we SHALL be 0.

Verification
REQ-038 Reset, then addu (op 0, func 0x21) -> states 0,1,2,4; reg_we=1 and rd_sel=0 in cycle 4; retired=1.
REQ-039 lw with dmem_ready high on the 3rd MEM cycle -> dmem_req for 3 cycles, then WB with mem_to_reg=1 and rd_sel=1; total 7 cycles.
REQ-040 beq with zero=1 -> pc_we=1, npc_sel=1 in EXEC; with zero=0 -> pc_we=0; both retire after 3 cycles.
REQ-041 jal -> in DECODE pc_we=1, npc_sel=2, jal_sel=1, reg_we=1; next state FETCH.
REQ-042 sw with dmem_ready held 0 and TIMEOUT=4 -> 4 MEM cycles, err=1, return to FETCH, retired unchanged; reset clears err.
REQ-043 reset asserted during the 2nd MEM cycle of lw -> next cycle state=0, dmem_req=0, retired=0, no reg_we.
